// File: rtl/i2s_stream_tx.sv
// Stereo I2S / left-justified serializer with a slave-mode bit clock.
// Frames arrive over valid/ready into a small FIFO and leave MSB-first on sdout.
`timescale 1ns/1ps
module i2s_stream_tx #(
  parameter int SAMPLE_W      = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int MCLK_DIV_LOG2 = 2,
  parameter int MODE_LJ       = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [SAMPLE_W-1:0]                s_left,
  input  logic [SAMPLE_W-1:0]                s_right,
  input  logic                               sclk_in,
  input  logic                               lrclk_in,
  output logic                               mclk_out,
  output logic                               sdout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic [15:0]                        underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(SAMPLE_W+2);
  localparam logic [BW-1:0]       IDX_MAX  = BW'(SAMPLE_W+1);
  localparam logic [LW-1:0]       FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [SAMPLE_W-1:0] MSB_ONE  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [MCLK_DIV_LOG2-1:0] mclk_cnt;
  logic [1:0]               sclk_sync, lr_sync;
  logic                     sclk_hist, lr_prev;
  logic [SAMPLE_W-1:0]      shadow_l, shadow_r, shadow_l_nxt, shadow_r_nxt, cur_word;
  logic                     playing, playing_nxt;
  logic [BW-1:0]            bit_idx, edge_idx, bit_pos;
  logic                     sdout_nxt;
  logic [SAMPLE_W-1:0]      mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            level;
  logic                     lr_s, sclk_fall, new_slot, frame_start;
  logic                     fifo_empty, push, pop, underrun_inc;

  assign lr_s         = lr_sync[1];
  assign sclk_fall    = sclk_hist & ~sclk_sync[1];
  assign new_slot     = sclk_fall && (lr_s != lr_prev);
  assign frame_start  = new_slot && lr_prev && !lr_s;
  assign fifo_empty   = (level == '0);
  assign s_ready      = (level != FULL_LVL);
  assign push         = s_valid && s_ready;
  assign pop          = frame_start && enable && !fifo_empty;
  assign underrun_inc = frame_start && enable && fifo_empty;
  assign fifo_level   = level;
  assign mclk_out     = mclk_cnt[MCLK_DIV_LOG2-1];

  // Frame-start loads are visible in the same cycle so the LJ MSB leaves on the slot edge.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    shadow_l_nxt = shadow_l;
    shadow_r_nxt = shadow_r;
    playing_nxt  = playing;
    if (frame_start) begin
      playing_nxt = enable;
      if (enable) begin
        if (fifo_empty) begin
          shadow_l_nxt = '0;
          shadow_r_nxt = '0;
        end else begin
          shadow_l_nxt = mem_l[rd_ptr];
          shadow_r_nxt = mem_r[rd_ptr];
        end
      end
    end
  end

  always_comb begin
    edge_idx = '0;
    if (!new_slot) edge_idx = (bit_idx == IDX_MAX) ? IDX_MAX : bit_idx + 1'b1;
    cur_word = lr_s ? shadow_r_nxt : shadow_l_nxt;
    bit_pos  = (MODE_LJ != 0) ? edge_idx : edge_idx - 1'b1;
    // Positions past the sample width select nothing, which yields the zero padding.
    sdout_nxt = playing_nxt && |(cur_word & (MSB_ONE >> bit_pos));
    if (MODE_LJ == 0 && edge_idx == '0) sdout_nxt = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt     <= '0;
      sclk_sync    <= '0;
      lr_sync      <= '0;
      sclk_hist    <= 1'b0;
      lr_prev      <= 1'b0;
      shadow_l     <= '0;
      shadow_r     <= '0;
      playing      <= 1'b0;
      bit_idx      <= '0;
      sdout        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      underrun_cnt <= '0;
    end else begin
      mclk_cnt  <= mclk_cnt + 1'b1;
      sclk_sync <= {sclk_sync[0], sclk_in};
      lr_sync   <= {lr_sync[0], lrclk_in};
      sclk_hist <= sclk_sync[1];
      shadow_l  <= shadow_l_nxt;
      shadow_r  <= shadow_r_nxt;
      playing   <= playing_nxt;
      if (sclk_fall) begin
        lr_prev <= lr_s;
        bit_idx <= edge_idx;
        sdout   <= sdout_nxt;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (underrun_inc && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and level alone define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

endmodule
